tug_score_ctrl: RTL and testbench
=================================

# tug_score_ctrl

Game-state and score producer for the tug-of-war display. Turns per-player point strobes from the note-detection logic into the 5-bit rope position (0..20, centre 10) that the tug-of-war glyph renderer consumes. It also sequences start, play and win. The score changes only on a frame boundary, so the renderer, which decodes score combinationally, never sees a mid-frame change.

## Interface
Parameters:
- CENTER, 5'd10, score loaded at reset and at game start
- MAX_SCORE, 5'd20, score at which the right player wins; 0 is the left-win score
- LOCKOUT_CYCLES, 16'd50000, clk cycles during which further point edges are ignored after an accepted point
- RESTART_FRAMES, 8'd120, frameTick count spent in a win state before auto-restart (used only with the macro below)

Ports:
- clk  input  1  system clock; single clock domain
- reset  input  1  synchronous, active-high
- frameTick  input  1  one-cycle pulse at the start of vertical blanking
- gameStart  input  1  level; sampled every cycle
- leftPoint  input  1  level; rising edge = left player scores
- rightPoint  input  1  level; rising edge = right player scores
- score  output  5  rope position, registered
- gameActive  output  1  high in PLAY
- leftWins  output  1  high in LEFT_WIN
- rightWins  output  1  high in RIGHT_WIN

## Operation
- States: IDLE, PLAY, LEFT_WIN, RIGHT_WIN. Outputs decode directly from state registers; no combinational paths from inputs.
- Reset: state IDLE, score = CENTER, gameActive/leftWins/rightWins = 0, pending = none, lockout = 0, edge-detect history = 0. Reset asserted mid-game overrides everything in that cycle.
- gameStart = 1 in IDLE, LEFT_WIN or RIGHT_WIN: go to PLAY, score = CENTER, pending cleared, lockout cleared.
- gameStart = 1 in PLAY: ignored.
- Edge detect: each point input is registered once; rising edge = current & ~previous.
- An edge is accepted only when all of these hold:
  - state is PLAY
  - lockout = 0
  - pending = none
  - exactly one of the two inputs has a rising edge this cycle
- Both inputs rising in the same cycle: both edges are discarded and lockout is not loaded.
- Accepted edge: pending = LEFT or RIGHT, and lockout loads LOCKOUT_CYCLES. Lockout then decrements by 1 per cycle, saturating at 0.
- On frameTick in PLAY with pending ≠ none:
  - LEFT pending: score − 1.
  - RIGHT pending: score + 1.
  - Pending is cleared.
  - If the new score = 0, go to LEFT_WIN. If the new score = MAX_SCORE, go to RIGHT_WIN. Both happen on the same edge as the score update.
- Score is never below 0 or above MAX_SCORE; no wrap. Win states freeze score, ignore point edges and drop pending.
- frameTick with pending = none: no change.

## Timing
- Edge accepted in cycle N: pending is visible in N+1. A frameTick in cycle N itself does not apply that edge; it applies on the next frameTick.
- Score update latency from frameTick: 1 clk (registered on the frameTick edge).
- Point-to-score latency: 2 clk minimum, one frame + 2 clk maximum.
- gameStart to gameActive = 1 and score = CENTER: 1 clk.
- At most one score step per frame. Point edges are not queued beyond one pending.

## Configuration
- TUG_AUTO_RESTART_EN defined:
  - In LEFT_WIN or RIGHT_WIN, an 8-bit counter counts frameTick pulses. It is cleared on entry to the win state.
  - On the frameTick that makes count = RESTART_FRAMES, go to IDLE with score = CENTER.
  - gameStart still takes priority and goes straight to PLAY.
- TUG_AUTO_RESTART_EN undefined: no counter is built, and win states are left only by gameStart or reset.

## Test plan
- Reset, then gameStart pulse → gameActive = 1 and score = 10 after 1 clk. leftWins = rightWins = 0.
- In PLAY: one rightPoint edge, then frameTick → score = 11 one clk after frameTick. A second rightPoint edge inside the lockout window → ignored, and the score stays 11 after the next frameTick.
- Simultaneous leftPoint and rightPoint rising edges → no pending, lockout stays 0, score unchanged after frameTick. A single leftPoint edge on the next cycle is accepted.
- 10 left points spaced beyond lockout, each followed by frameTick → score steps 10→0, then leftWins = 1 and gameActive = 0. A further leftPoint edge plus frameTick → score stays 0.
- From score 19, one rightPoint edge plus frameTick → score = 20 and rightWins = 1. With TUG_AUTO_RESTART_EN: after 120 frameTicks, state IDLE and score = 10. Without it: still RIGHT_WIN after 200 frameTicks.
- reset asserted for one cycle mid-PLAY with a point pending → next cycle state IDLE, score = 10. The following frameTick applies no step.

Source files
------------

// File: rtl/tug_score_ctrl.sv
// rtl/tug_score_ctrl.sv - tug-of-war game state and rope score producer (optional macro: TUG_AUTO_RESTART_EN)
module tug_score_ctrl #(
    parameter logic [4:0]  CENTER         = 5'd10,
    parameter logic [4:0]  MAX_SCORE      = 5'd20,
    parameter logic [15:0] LOCKOUT_CYCLES = 16'd50000,
    parameter logic [7:0]  RESTART_FRAMES = 8'd120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frameTick,
    input  logic       gameStart,
    input  logic       leftPoint,
    input  logic       rightPoint,
    output logic [4:0] score,
    output logic       gameActive,
    output logic       leftWins,
    output logic       rightWins
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_LEFT_WIN, S_RIGHT_WIN} state_t;
    typedef enum logic [1:0] {P_NONE, P_LEFT, P_RIGHT} pend_t;

    state_t      r_state, w_state_nxt;
    pend_t       r_pend, w_pend_nxt;
    logic [4:0]  r_score, w_score_nxt;
    logic [15:0] r_lock, w_lock_nxt;
    logic        r_left_d, r_right_d;
    logic        w_left_rise, w_right_rise;
    logic        w_can_accept;

`ifdef TUG_AUTO_RESTART_EN
    logic [7:0]  r_restart_cnt, w_restart_cnt_nxt;
    logic [7:0]  w_restart_cnt_inc;
`else
    logic [7:0]  w_unused_restart;
    assign w_unused_restart = RESTART_FRAMES;
`endif

    assign w_left_rise  = leftPoint & ~r_left_d;
    assign w_right_rise = rightPoint & ~r_right_d;
    assign w_can_accept = (r_state == S_PLAY) && (r_lock == 16'd0) && (r_pend == P_NONE);

    // Flags decode straight from the state register so nothing combinational reaches the renderer.
    assign score      = r_score;
    assign gameActive = (r_state == S_PLAY);
    assign leftWins   = (r_state == S_LEFT_WIN);
    assign rightWins  = (r_state == S_RIGHT_WIN);

    // State, score, pending point, lockout and edge history registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pend    <= P_NONE;
            r_score   <= CENTER;
            r_lock    <= 16'd0;
            r_left_d  <= 1'b0;
            r_right_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pend    <= w_pend_nxt;
            r_score   <= w_score_nxt;
            r_lock    <= w_lock_nxt;
            r_left_d  <= leftPoint;
            r_right_d <= rightPoint;
        end
    end

`ifdef TUG_AUTO_RESTART_EN
    // Frame counter used to leave a win state on its own.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_restart_cnt <= 8'd0;
        end else begin
            r_restart_cnt <= w_restart_cnt_nxt;
        end
    end
    assign w_restart_cnt_inc = r_restart_cnt + 8'd1;
`endif

    // Next-state logic: point acceptance, frame-aligned score step and win detection.
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_score_nxt = r_score;
        w_lock_nxt  = (r_lock != 16'd0) ? r_lock - 16'd1 : 16'd0;
`ifdef TUG_AUTO_RESTART_EN
        w_restart_cnt_nxt = r_restart_cnt;
`endif
        case (r_state)
            S_PLAY: begin
                // A pending point and a fresh accept are mutually exclusive, so order does not matter.
                if (frameTick && (r_pend != P_NONE)) begin
                    w_pend_nxt = P_NONE;
                    if (r_pend == P_LEFT) begin
                        if (r_score != 5'd0) w_score_nxt = r_score - 5'd1;
                        if (r_score <= 5'd1) w_state_nxt = S_LEFT_WIN;
                    end else begin
                        if (r_score != MAX_SCORE) w_score_nxt = r_score + 5'd1;
                        if (r_score >= MAX_SCORE - 5'd1) w_state_nxt = S_RIGHT_WIN;
                    end
`ifdef TUG_AUTO_RESTART_EN
                    w_restart_cnt_nxt = 8'd0;
`endif
                end
                if (w_can_accept && (w_left_rise ^ w_right_rise)) begin
                    w_pend_nxt = w_left_rise ? P_LEFT : P_RIGHT;
                    w_lock_nxt = LOCKOUT_CYCLES;
                end
            end
            S_LEFT_WIN, S_RIGHT_WIN: begin
                w_pend_nxt = P_NONE;
`ifdef TUG_AUTO_RESTART_EN
                if (frameTick) begin
                    w_restart_cnt_nxt = w_restart_cnt_inc;
                    if (w_restart_cnt_inc == RESTART_FRAMES) begin
                        w_state_nxt = S_IDLE;
                        w_score_nxt = CENTER;
                    end
                end
`endif
            end
            default: begin
                w_pend_nxt = P_NONE;
            end
        endcase
        // Starting a game wins over everything except reset.
        if (gameStart && (r_state != S_PLAY)) begin
            w_state_nxt = S_PLAY;
            w_score_nxt = CENTER;
            w_pend_nxt  = P_NONE;
            w_lock_nxt  = 16'd0;
        end
    end

endmodule

// File: tb/tb_tug_score_ctrl.sv
// tb/tb_tug_score_ctrl.sv - scoreboard bench for tug_score_ctrl
module tb_tug_score_ctrl;

    localparam int LOCK = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frameTick = 1'b0;
    logic       gameStart = 1'b0;
    logic       leftPoint = 1'b0;
    logic       rightPoint = 1'b0;
    logic [4:0] score;
    logic       gameActive, leftWins, rightWins;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string      tag;
        int         kind;
        logic [7:0] exp;
    } sb_t;
    sb_t q[$];

    tug_score_ctrl #(
        .CENTER(5'd10),
        .MAX_SCORE(5'd20),
        .LOCKOUT_CYCLES(16'(LOCK)),
        .RESTART_FRAMES(8'd120)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frameTick(frameTick),
        .gameStart(gameStart),
        .leftPoint(leftPoint),
        .rightPoint(rightPoint),
        .score(score),
        .gameActive(gameActive),
        .leftWins(leftWins),
        .rightWins(rightWins)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string tag, input int kind, input int v);
        sb_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = v[7:0];
        q.push_back(e);
    endtask

    task automatic expect_all(input string tag, input int sc, input int ga, input int lw, input int rw);
        expect_v({tag, "_score"}, 0, sc);
        expect_v({tag, "_active"}, 1, ga);
        expect_v({tag, "_leftwins"}, 2, lw);
        expect_v({tag, "_rightwins"}, 3, rw);
    endtask

    task automatic check_all();
        while (q.size() > 0) begin
            sb_t e;
            logic [7:0] obs;
            e = q.pop_front();
            case (e.kind)
                0:       obs = {3'b000, score};
                1:       obs = {7'd0, gameActive};
                2:       obs = {7'd0, leftWins};
                default: obs = {7'd0, rightWins};
            endcase
            tests++;
            assert (obs === e.exp) else begin
                fails++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic frame();
        frameTick = 1'b1;
        tick();
        frameTick = 1'b0;
    endtask

    task automatic point(input bit l, input bit r);
        leftPoint  = l;
        rightPoint = r;
        tick();
        leftPoint  = 1'b0;
        rightPoint = 1'b0;
        tick();
    endtask

    task automatic wait_lock();
        repeat (LOCK + 3) tick();
    endtask

    task automatic start_game();
        gameStart = 1'b1;
        tick();
        gameStart = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        reset = 1'b0;
        expect_all("reset", 10, 0, 0, 0);
        check_all();

        start_game();
        expect_all("start", 10, 1, 0, 0);
        check_all();

        point(0, 1);
        expect_v("right_before_frame", 0, 10);
        check_all();
        frame();
        expect_v("right_step", 0, 11);
        check_all();
        point(0, 1);
        frame();
        expect_v("right_in_lockout", 0, 11);
        check_all();

        wait_lock();
        point(1, 1);
        frame();
        expect_v("simultaneous", 0, 11);
        check_all();
        leftPoint = 1'b1;
        tick();
        leftPoint = 1'b0;
        tick();
        frame();
        expect_v("left_after_simul", 0, 10);
        check_all();

        for (int i = 1; i <= 10; i++) begin
            wait_lock();
            point(1, 0);
            frame();
            expect_v($sformatf("left_walk_%0d", i), 0, 10 - i);
            check_all();
        end
        expect_all("left_win", 0, 0, 1, 0);
        check_all();
        wait_lock();
        point(1, 0);
        frame();
        expect_all("left_win_frozen", 0, 0, 1, 0);
        check_all();

        start_game();
        expect_all("restart_play", 10, 1, 0, 0);
        check_all();
        for (int i = 1; i <= 9; i++) begin
            wait_lock();
            point(0, 1);
            frame();
        end
        expect_all("score19", 19, 1, 0, 0);
        check_all();
        wait_lock();
        point(0, 1);
        frame();
        expect_all("right_win", 20, 0, 0, 1);
        check_all();

`ifdef TUG_AUTO_RESTART_EN
        repeat (119) begin
            frame();
            tick();
        end
        expect_all("auto_119", 20, 0, 0, 1);
        check_all();
        frame();
        expect_all("auto_restart", 10, 0, 0, 0);
        check_all();
`else
        repeat (200) begin
            frame();
            tick();
        end
        expect_all("no_auto_200", 20, 0, 0, 1);
        check_all();
`endif

        start_game();
        wait_lock();
        point(0, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_all("mid_reset", 10, 0, 0, 0);
        check_all();
        frame();
        expect_all("mid_reset_frame", 10, 0, 0, 0);
        check_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
